register_file_write_packer_32b: RTL and testbench
=================================================

// Module: register_file_write_packer_32b
// PURPOSE
//  Write-side front end of the 1W-128b / multi-port-read-32b latch register file.
//  Accepts a valid/ready stream of 32b words and packs four consecutive words into one 128b line.
//  Issues one single-cycle WriteEnable/WriteAddr/WriteData transaction per line at an auto-incrementing line address.
//  Lane 0 holds the first word of a line; this matches the 32b read address order (line*4 + lane).
// PARAMETERS
//  WADDR_WIDTH   5         line address width; NUM_LINES = 2**WADDR_WIDTH
//  WDATA_WIDTH   128       line width driven to the register file
//  RDATA_WIDTH   32        input word width; LANES = WDATA_WIDTH/RDATA_WIDTH (must be 4)
//  FILL_VALUE    32'h0     value written into lanes that are still empty when a partial line is flushed
// PORTS
//  clk           in   1            clock
//  rst_n         in   1            asynchronous reset, active low
//  start_i       in   1            in IDLE: load base_addr_i, enter FILL; ignored otherwise
//  base_addr_i   in   WADDR_WIDTH  first line address of the stream
//  flush_i       in   1            write the partial line (if any), then return to IDLE
//  in_valid_i    in   1            input word valid
//  in_ready_o    out  1            input word accepted when valid && ready
//  in_data_i     in   RDATA_WIDTH  input word
//  WriteEnable   out  1            to register file; one-cycle pulse
//  WriteAddr     out  WADDR_WIDTH  to register file
//  WriteData     out  WDATA_WIDTH  to register file; lane k = bits [32k+31:32k]
//  busy_o        out  1            high when not in IDLE
//  wrap_o        out  1            one-cycle pulse with a write to line NUM_LINES-1
// BEHAVIOUR
//  - Reset: state IDLE, lane_cnt=0, line_addr=0, accumulator=0.
//    All outputs are 0: in_ready_o, WriteEnable, WriteAddr, WriteData, busy_o, wrap_o.
//  - Outputs are registered. A reset during FILL or EMIT discards the partial line; no write is issued.
//  - FSM states: IDLE, FILL, EMIT.
//    IDLE:  in_ready_o=0. start_i -> FILL, line_addr<=base_addr_i, lane_cnt<=0. flush_i alone has no effect.
//    FILL:  in_ready_o=1. An accepted beat stores in_data_i in lane[lane_cnt], then lane_cnt++.
//           4th beat (lane_cnt 3->4), or flush_i with lane_cnt>0 -> EMIT.
//           flush_i with lane_cnt==0 -> IDLE, no write.
//    EMIT:  in_ready_o=0, WriteEnable=1 for exactly one cycle.
//           WriteAddr=line_addr; WriteData=accumulator, with empty lanes set to FILL_VALUE.
//           After EMIT: line_addr<=line_addr+1 mod NUM_LINES (wraps NUM_LINES-1 -> 0); lane_cnt<=0; accumulator<=0.
//           Next state is IDLE if the line was emitted because of a flush, otherwise FILL.
//  - Simultaneous flush_i and accepted beat in FILL: the beat is stored first, and the emitted line includes it.
//  - flush_i asserted during EMIT is latched (flush_pend) and taken on the next FILL cycle.
//  - Throughput: at most 4 words per 5 cycles.
//  - WriteEnable is never high on two consecutive cycles; this is required by the gated-clock latch write path.
//  - Latency: the 4th accepted beat at cycle N produces WriteEnable at cycle N+1.
//  - wrap_o is high in EMIT iff line_addr==NUM_LINES-1.
// CONFIGURATION
//  REGISTER_FILE_WRITE_PACKER_PERF_EN
//   - Defined: adds output lines_written_o[31:0] and output partial_flushes_o[31:0].
//     Both are saturating counters, reset to 0.
//     lines_written_o increments on every EMIT; partial_flushes_o increments on every EMIT with lane_cnt<4.
//   - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package register_file_write_packer_pkg holds:
//    typedef enum logic [1:0] {IDLE, FILL, EMIT} packer_state_e;
//    localparam LANES = 4; localparam LANE_CNT_W = 3.
//  - Single module, no sub-modules. The lane accumulator is LANES x RDATA_WIDTH flops with per-lane enable.
// TESTING
//  1. Reset, start_i with base=0, then 4 beats 0x11,0x22,0x33,0x44 back-to-back
//     -> one WriteEnable pulse, WriteAddr=0, WriteData=0x00000044_00000033_00000022_00000011.
//  2. base=31, then 8 beats -> writes to line 31 (wrap_o=1) and then line 0 (wrap_o=0).
//     in_ready_o is low exactly in the 2 EMIT cycles.
//  3. 2 beats 0xA,0xB, then flush_i -> WriteData=0x0_0_B_A, then IDLE with busy_o=0.
//     With REGISTER_FILE_WRITE_PACKER_PERF_EN: partial_flushes_o=1.
//  4. flush_i in FILL with 0 beats stored -> no WriteEnable, state IDLE.
//     flush_i together with the 4th beat -> one full write, then IDLE.
//  5. rst_n asserted after 3 beats -> no WriteEnable, all outputs 0.
//     After release, start_i plus 4 beats writes to base_addr_i.
//  6. Random valid gaps over 1000 beats, with a read-back model of the register file
//     -> WriteEnable is never high on consecutive cycles; every 32b word reads back at address line*4+lane.

Source files
------------

// File: rtl/register_file_write_packer_pkg.sv
// ============================================================================
// Module  : register_file_write_packer_pkg
// Purpose : Shared types and constants for the register-file write packer.
//           Holds the FSM state encoding, the lane count of one write line,
//           the width of the lane counter, and a small helper that reports
//           whether a lane of the line under construction holds a word.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package register_file_write_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } packer_state_e;

  // Number of 32b words packed into one register-file line.
  localparam int LANES      = 4;
  // Lane counter runs 0..LANES inclusive, so it needs one extra bit.
  localparam int LANE_CNT_W = 3;

  // A lane holds a word when its index is below the number of words stored.
  function automatic logic lane_filled(input logic [LANE_CNT_W-1:0] cnt,
                                       input int                    lane);
    return (int'(cnt) > lane);
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_write_packer_32b.sv
// ============================================================================
// Module  : register_file_write_packer_32b
// Purpose : Write-side front end of the 1W-128b / multi-port-read-32b latch
//           register file. Packs four consecutive 32b stream words into one
//           128b line (lane 0 = first word, matching read address
//           line*4 + lane) and issues one single-cycle write per line at an
//           auto-incrementing line address.
// Ports   : clk, rst_n            clock, asynchronous active-low reset
//           start_i, base_addr_i  open a stream at line base_addr_i
//           flush_i               write any partial line, then go idle
//           in_valid_i/in_ready_o/in_data_i   32b input word stream
//           WriteEnable/WriteAddr/WriteData   register-file write port
//           busy_o                high whenever the packer is not idle
//           wrap_o                pulses with a write to the last line
//           lines_written_o, partial_flushes_o  (optional) saturating
//                                 performance counters
// Config  : REGISTER_FILE_WRITE_PACKER_PERF_EN adds the two performance
//           counters and their output ports.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file_write_packer_32b
  import register_file_write_packer_pkg::*;
#(
  parameter int                     WADDR_WIDTH = 5,
  parameter int                     WDATA_WIDTH = 128,
  parameter int                     RDATA_WIDTH = 32,
  parameter logic [RDATA_WIDTH-1:0] FILL_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [WADDR_WIDTH-1:0] base_addr_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [RDATA_WIDTH-1:0] in_data_i,
  output logic                   WriteEnable,
  output logic [WADDR_WIDTH-1:0] WriteAddr,
  output logic [WDATA_WIDTH-1:0] WriteData,
`ifdef REGISTER_FILE_WRITE_PACKER_PERF_EN
  output logic [31:0]            lines_written_o,
  output logic [31:0]            partial_flushes_o,
`endif
  output logic                   busy_o,
  output logic                   wrap_o
);

  // WDATA_WIDTH must equal LANES * RDATA_WIDTH; the line is built as a
  // packed LANES x RDATA_WIDTH array and assigned straight to WriteData.

  localparam logic [LANE_CNT_W-1:0]  c_lanes_full = LANE_CNT_W'(LANES);
  localparam logic [WADDR_WIDTH-1:0] c_last_line  = '1;
  localparam logic [WADDR_WIDTH-1:0] c_addr_one   = WADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  packer_state_e                          r_state;
  packer_state_e                          w_state_nxt;
  logic [LANE_CNT_W-1:0]                  r_lane_cnt;
  logic [WADDR_WIDTH-1:0]                 r_line_addr;
  logic [LANES-1:0][RDATA_WIDTH-1:0]      r_acc;
  // flush_i seen during EMIT, acted on in the following FILL cycle
  logic                                   r_flush_pend;
  // the line now in EMIT was closed by a flush, so return to IDLE after it
  logic                                   r_emit_flush;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                                   w_accept;
  logic                                   w_flush;
  logic [LANE_CNT_W-1:0]                  w_cnt_nxt;
  logic [LANES-1:0]                       w_lane_en;
  logic [LANES-1:0][RDATA_WIDTH-1:0]      w_acc_nxt;
  logic [LANES-1:0][RDATA_WIDTH-1:0]      w_line_word;

  // in_ready_o is registered and is high exactly while in FILL, so an accept
  // can only happen in FILL.
  assign w_accept  = in_valid_i & in_ready_o;
  assign w_flush   = (flush_i | r_flush_pend) & (r_state == FILL);
  assign w_cnt_nxt = r_lane_cnt + LANE_CNT_W'(w_accept);

  // The outgoing line is formed from the accumulator as it will look after
  // this cycle's beat, so the beat that closes a line (fourth word, or a beat
  // that arrives together with flush) is included in the write.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_lane_en[k]   = w_accept & (r_lane_cnt == LANE_CNT_W'(k));
    assign w_acc_nxt[k]   = w_lane_en[k] ? in_data_i : r_acc[k];
    assign w_line_word[k] = lane_filled(w_cnt_nxt, k) ? w_acc_nxt[k]
                                                      : FILL_VALUE;

    // Per-lane enabled accumulator word; cleared once its line is written.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc[k] <= '0;
      end else if (r_state == EMIT) begin
        r_acc[k] <= '0;
      end else if (w_lane_en[k]) begin
        r_acc[k] <= in_data_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if ((w_cnt_nxt == c_lanes_full) || (w_flush && (w_cnt_nxt != '0))) begin
          w_state_nxt = EMIT;
        end else if (w_flush) begin
          // nothing stored: close the stream without a write
          w_state_nxt = IDLE;
        end
      end
      EMIT: begin
        w_state_nxt = r_emit_flush ? IDLE : FILL;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. All outputs are registered, so their next values are
  // derived from the next state; WriteEnable is therefore high exactly for
  // the single cycle spent in EMIT and can never repeat on the next cycle,
  // because EMIT always leaves to FILL or IDLE.
  // --------------------------------------------------------------------------
  logic                   w_in_ready_nxt;
  logic                   w_we_nxt;
  logic [WADDR_WIDTH-1:0] w_waddr_nxt;
  logic [WDATA_WIDTH-1:0] w_wdata_nxt;
  logic                   w_busy_nxt;
  logic                   w_wrap_nxt;

  always_comb begin
    w_in_ready_nxt = (w_state_nxt == FILL);
    w_busy_nxt     = (w_state_nxt != IDLE);
    w_we_nxt       = 1'b0;
    w_waddr_nxt    = '0;
    w_wdata_nxt    = '0;
    w_wrap_nxt     = 1'b0;
    if (w_state_nxt == EMIT) begin
      // EMIT is only entered from FILL, where r_line_addr is already stable.
      w_we_nxt    = 1'b1;
      w_waddr_nxt = r_line_addr;
      w_wdata_nxt = w_line_word;
      w_wrap_nxt  = (r_line_addr == c_last_line);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      wrap_o      <= 1'b0;
    end else begin
      in_ready_o  <= w_in_ready_nxt;
      busy_o      <= w_busy_nxt;
      WriteEnable <= w_we_nxt;
      WriteAddr   <= w_waddr_nxt;
      WriteData   <= w_wdata_nxt;
      wrap_o      <= w_wrap_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Lane counter, line address and flush bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_cnt   <= '0;
      r_line_addr  <= '0;
      r_flush_pend <= 1'b0;
      r_emit_flush <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_flush_pend <= 1'b0;
          if (start_i) begin
            r_line_addr <= base_addr_i;
            r_lane_cnt  <= '0;
          end
        end
        FILL: begin
          r_lane_cnt   <= w_cnt_nxt;
          r_flush_pend <= 1'b0;
          r_emit_flush <= w_flush;
        end
        EMIT: begin
          // address width makes NUM_LINES-1 -> 0 wrap automatic
          r_line_addr  <= r_line_addr + c_addr_one;
          r_lane_cnt   <= '0;
          // a flush arriving while a flush-closed line is written is
          // redundant, the stream is already ending
          r_flush_pend <= flush_i & ~r_emit_flush;
        end
        default: begin
          r_lane_cnt   <= '0;
          r_flush_pend <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGISTER_FILE_WRITE_PACKER_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters. In EMIT, r_lane_cnt still holds the
  // number of words in the line being written.
  // --------------------------------------------------------------------------
  logic [31:0] r_lines_written;
  logic [31:0] r_partial_flushes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lines_written   <= '0;
      r_partial_flushes <= '0;
    end else if (r_state == EMIT) begin
      if (r_lines_written != '1) begin
        r_lines_written <= r_lines_written + 32'd1;
      end
      if ((r_lane_cnt < c_lanes_full) && (r_partial_flushes != '1)) begin
        r_partial_flushes <= r_partial_flushes + 32'd1;
      end
    end
  end

  assign lines_written_o   = r_lines_written;
  assign partial_flushes_o = r_partial_flushes;
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_file_write_packer_32b.sv
// ============================================================================
// Module  : tb_register_file_write_packer_32b
// Purpose : Directed self-checking bench for register_file_write_packer_32b.
//           A negedge monitor keeps a model of the 32 x 128b register file
//           and a log of every write; directed sequences compare against
//           hand-computed values.
// Config  : REGISTER_FILE_WRITE_PACKER_PERF_EN enables the counter checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_file_write_packer_32b;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [4:0]   base_addr_i;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic         WriteEnable;
  logic [4:0]   WriteAddr;
  logic [127:0] WriteData;
  logic         busy_o;
  logic         wrap_o;
`ifdef REGISTER_FILE_WRITE_PACKER_PERF_EN
  logic [31:0]  lines_written_o;
  logic [31:0]  partial_flushes_o;
`endif

  register_file_write_packer_32b dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .base_addr_i       (base_addr_i),
    .flush_i           (flush_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .in_data_i         (in_data_i),
    .WriteEnable       (WriteEnable),
    .WriteAddr         (WriteAddr),
    .WriteData         (WriteData),
`ifdef REGISTER_FILE_WRITE_PACKER_PERF_EN
    .lines_written_o   (lines_written_o),
    .partial_flushes_o (partial_flushes_o),
`endif
    .busy_o            (busy_o),
    .wrap_o            (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Register-file model and write log
  // --------------------------------------------------------------------------
  logic [127:0] rf [32];
  logic [4:0]   wa_log[$];
  logic [127:0] wd_log[$];
  logic         wrap_log[$];
  logic         prev_we = 1'b0;
  int           ready_low_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (WriteEnable) begin
        check("we_gap", 128'(prev_we), 128'd0);
        rf[WriteAddr] = WriteData;
        wa_log.push_back(WriteAddr);
        wd_log.push_back(WriteData);
        wrap_log.push_back(wrap_o);
      end
      if (busy_o && !in_ready_o) ready_low_cnt++;
      prev_we = WriteEnable;
    end else begin
      prev_we = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after each rising edge
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [4:0] base);
    start_i     = 1'b1;
    base_addr_i = base;
    step();
    start_i     = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    int guard;
    guard      = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!in_ready_o && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("push_timeout", 128'd1, 128'd0);
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  logic [31:0] exp_mem [128];
  int          nw;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; flush_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0;
    repeat (2) step();

    // ---- reset state
    check("rst_we",    128'(WriteEnable), 128'd0);
    check("rst_ready", 128'(in_ready_o),  128'd0);
    check("rst_busy",  128'(busy_o),      128'd0);
    check("rst_wrap",  128'(wrap_o),      128'd0);
    check("rst_waddr", 128'(WriteAddr),   128'd0);
    check("rst_wdata", WriteData,         128'd0);
    rst_n = 1'b1;
    step();

    // ---- 1: one full line at base 0; write visible the cycle after beat 4
    start_stream(5'd0);
    check("t1_ready", 128'(in_ready_o), 128'd1);
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    check("t1_we",    128'(WriteEnable), 128'd1);
    check("t1_waddr", 128'(WriteAddr),   128'd0);
    check("t1_wdata", WriteData, 128'h00000044_00000033_00000022_00000011);
    check("t1_ready_emit", 128'(in_ready_o), 128'd0);
    step();
    check("t1_we_drop", 128'(WriteEnable), 128'd0);
    check("t1_busy",    128'(busy_o),      128'd1);

    // ---- 4a: flush with nothing stored -> idle, no write
    nw = wd_log.size();
    pulse_flush();
    check("t4a_busy",   128'(busy_o),      128'd0);
    step();
    check("t4a_nowr",   128'(wd_log.size()), 128'(nw));

    // ---- 2: base 31, 8 beats -> lines 31 (wrap) then 0
    nw = wd_log.size();
    ready_low_cnt = 0;
    start_stream(5'd31);
    for (int i = 0; i < 8; i++) push(32'hC000_0000 + 32'(i));
    step();
    check("t2_ready_low", 128'(ready_low_cnt), 128'd2);
    check("t2_nwr",   128'(wd_log.size() - nw), 128'd2);
    check("t2_addr0", 128'(wa_log[nw]),   128'd31);
    check("t2_wrap0", 128'(wrap_log[nw]), 128'd1);
    check("t2_data0", wd_log[nw],
          128'hC0000003_C0000002_C0000001_C0000000);
    check("t2_addr1", 128'(wa_log[nw+1]),   128'd0);
    check("t2_wrap1", 128'(wrap_log[nw+1]), 128'd0);
    check("t2_data1", wd_log[nw+1],
          128'hC0000007_C0000006_C0000005_C0000004);
    pulse_flush();
    check("t2_idle", 128'(busy_o), 128'd0);

    // ---- 3: two beats then flush -> partial line, empty lanes 0, then idle
    start_stream(5'd5);
    push(32'hA); push(32'hB);
    pulse_flush();
    check("t3_we",    128'(WriteEnable), 128'd1);
    check("t3_waddr", 128'(WriteAddr),   128'd5);
    check("t3_wdata", WriteData, 128'h00000000_00000000_0000000B_0000000A);
    step();
    check("t3_busy",  128'(busy_o), 128'd0);
`ifdef REGISTER_FILE_WRITE_PACKER_PERF_EN
    check("t3_partial", 128'(partial_flushes_o), 128'd1);
    check("t3_lines",   128'(lines_written_o),   128'd4);
`endif

    // ---- 4b: flush together with the 4th beat -> one full write, then idle
    nw = wd_log.size();
    start_stream(5'd10);
    push(32'h1); push(32'h2); push(32'h3);
    flush_i = 1'b1;
    push(32'h4);
    flush_i = 1'b0;
    check("t4b_we",    128'(WriteEnable), 128'd1);
    check("t4b_waddr", 128'(WriteAddr),   128'd10);
    check("t4b_wdata", WriteData, 128'h00000004_00000003_00000002_00000001);
    step();
    check("t4b_busy",  128'(busy_o), 128'd0);
    check("t4b_nwr",   128'(wd_log.size() - nw), 128'd1);

    // ---- flush during EMIT is held and taken in the following FILL cycle
    start_stream(5'd12);
    push(32'h5); push(32'h6); push(32'h7); push(32'h8);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("pend_fill", 128'(busy_o), 128'd1);
    step();
    check("pend_idle", 128'(busy_o), 128'd0);

    // ---- 5: reset mid-line discards it; restart writes to the new base
    nw = wd_log.size();
    start_stream(5'd20);
    push(32'hD1); push(32'hD2); push(32'hD3);
    rst_n = 1'b0;
    #2;
    check("t5_we",    128'(WriteEnable), 128'd0);
    check("t5_ready", 128'(in_ready_o),  128'd0);
    check("t5_busy",  128'(busy_o),      128'd0);
    check("t5_wdata", WriteData,         128'd0);
    step(); step();
    rst_n = 1'b1;
    check("t5_nowr",  128'(wd_log.size()), 128'(nw));
    start_stream(5'd7);
    push(32'hE1); push(32'hE2); push(32'hE3); push(32'hE4);
    check("t5_waddr", 128'(WriteAddr), 128'd7);
    check("t5_wdata", WriteData, 128'h000000E4_000000E3_000000E2_000000E1);
    step();
`ifdef REGISTER_FILE_WRITE_PACKER_PERF_EN
    check("t5_lines",   128'(lines_written_o),   128'd1);
    check("t5_partial", 128'(partial_flushes_o), 128'd0);
`endif
    pulse_flush();

    // ---- 6: 1000 beats with random gaps, read back at line*4+lane
    start_stream(5'd0);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      d = $urandom;
      exp_mem[i % 128] = d;
      in_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      push(d);
    end
    step(); step();
    pulse_flush();
    check("t6_idle", 128'(busy_o), 128'd0);
    for (int a = 0; a < 128; a++) begin
      logic [127:0] line;
      line = rf[a / 4];
      check($sformatf("t6_rd%0d", a), 128'(line[32*(a%4) +: 32]),
            128'(exp_mem[a]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
